// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer write engine and its address logic.
// Contents: FSM state type, address width, default frame size and sync byte.
package fb_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        RECV,
        WR_HI,
        WR_LO
    } fb_state_t;

    localparam int         ADDR_W        = 19;
    localparam int         BUFFER_SIZE   = 640 * 480;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/fb_addr_counter.sv
// Wrapping linear pixel address counter (shared with the read side).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr        force count to 0 (wins over inc)
//   inc        advance by one, wrapping from DEPTH-1 to 0
//   count      current address
//   last       count == DEPTH-1 (terminal count)
module fb_addr_counter #(
    parameter int DEPTH = 8,
    parameter int W     = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         last
);

    assign last = (count == W'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= last ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/framebuffer_writer.sv
// Byte-stream to frame buffer write engine. Each accepted byte carries two
// 4-bit pixels (high nibble first) written to consecutive linear addresses.
// A frame starts with SYNC_BYTE while idle and ends after the last pixel.
// Optional feature macro: FB_WRITER_TIMEOUT_EN (abort a stalled frame after
// TIMEOUT_CYCLES idle cycles in RECV).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_data/in_ready   byte stream handshake
//   wr_en/wr_addr/wr_data       frame buffer write port (registered)
//   busy                  frame in progress (state != WAIT_SYNC)
//   frame_done            1-cycle pulse after the final pixel write
//   abort                 1-cycle pulse on timeout (0 without the feature)
module framebuffer_writer
    import fb_pkg::*;
#(
    parameter int         VGA_WIDTH       = 640,
    parameter int         VGA_HEIGHT      = 480,
    parameter int         VGA_COLOR_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE       = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES  = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [VGA_COLOR_DEPTH-1:0] wr_data,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       abort
);

    localparam int FRAME_PIXELS = VGA_WIDTH * VGA_HEIGHT;

    // Pixels come in pairs, so an odd frame size could never end cleanly.
    generate
        if ((FRAME_PIXELS % 2) != 0 || VGA_COLOR_DEPTH != 4 ||
            FRAME_PIXELS > (1 << ADDR_W) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("framebuffer_writer: unsupported configuration");
        end
    endgenerate

    fb_state_t         state;
    logic [3:0]        lo_nib;
    logic              last_pix;
    logic              accept;
    logic              timeout_hit;
    logic              cnt_clr;
    logic              cnt_inc;
    logic [ADDR_W-1:0] addr;
    logic              addr_last;

    assign accept = in_valid && in_ready;

    // The counter advances as each write is registered, so during WR_HI it
    // already points at the low-nibble address.
    assign cnt_clr = (state == WAIT_SYNC && accept && in_data == SYNC_BYTE) || timeout_hit;
    assign cnt_inc = (state == RECV && accept) || (state == WR_HI);

    fb_addr_counter #(
        .DEPTH (FRAME_PIXELS),
        .W     (ADDR_W)
    ) u_addr (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (addr),
        .last  (addr_last)
    );

`ifdef FB_WRITER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    assign timeout_hit = (state == RECV) && !accept && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state != RECV || accept || timeout_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_SYNC;
            in_ready   <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            abort      <= 1'b0;
            lo_nib     <= '0;
            last_pix   <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            abort      <= 1'b0;
            case (state)
                WAIT_SYNC: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        state <= RECV;
                        busy  <= 1'b1;
                    end
                end
                RECV: begin
                    if (accept) begin
                        lo_nib   <= in_data[3:0];
                        wr_en    <= 1'b1;
                        wr_addr  <= addr;
                        wr_data  <= in_data[7:4];
                        in_ready <= 1'b0;
                        state    <= WR_HI;
                    end else if (timeout_hit) begin
                        state <= WAIT_SYNC;
                        busy  <= 1'b0;
                        abort <= 1'b1;
                    end
                end
                WR_HI: begin
                    wr_en    <= 1'b1;
                    wr_addr  <= addr;
                    wr_data  <= lo_nib;
                    last_pix <= addr_last;
                    state    <= WR_LO;
                end
                WR_LO: begin
                    in_ready <= 1'b1;
                    if (last_pix) begin
                        state      <= WAIT_SYNC;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        state <= RECV;
                    end
                end
                default: state <= WAIT_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Self-checking bench for framebuffer_writer on a 4x2 frame (8 pixels).
module tb_framebuffer_writer;

    localparam int SZ = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, wr_en, busy, frame_done, abort;
    logic [18:0] wr_addr;
    logic [3:0]  wr_data;

    int checks = 0;
    int failures = 0;

    framebuffer_writer #(
        .VGA_WIDTH       (4),
        .VGA_HEIGHT      (2),
        .VGA_COLOR_DEPTH (4),
        .SYNC_BYTE       (8'hA5),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one byte and hold it until the handshake completes (bounded).
    task automatic send(input logic [7:0] b, output bit ok);
        logic r;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 8; t++) begin
            r = in_ready;
            @(posedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout byte=%0h never accepted", b);
        end
    endtask

    // Write monitor for the randomized phase.
    bit          mon_en = 1'b0;
    logic [22:0] got[$];
    int          got_done = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_en) got.push_back({wr_addr, wr_data});
            if (frame_done) got_done++;
        end
    end

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [18:0] a;
        logic [3:0]  wd;
        logic        bsy;
        logic        dn;
    } vec_t;

    vec_t tbl[18];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          ok;
        logic [22:0] expq[$];
        int          exp_done;
        bit          in_frame;
        int          pix;
        logic [7:0]  b;
        int          n_abort, n_done;

        tbl[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 19'd0, 4'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h12, 1'b1, 1'b0, 19'd0, 4'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 19'd0, 4'h0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 19'd0, 4'h3, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 19'd1, 4'hC, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 19'd1, 4'hC, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 19'd2, 4'hA, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 8'h77, 1'b0, 1'b1, 19'd3, 4'h5, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 8'h77, 1'b1, 1'b0, 19'd3, 4'h5, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'h77, 1'b0, 1'b1, 19'd4, 4'h7, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 19'd5, 4'h7, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 8'hE1, 1'b1, 1'b0, 19'd5, 4'h7, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 8'hE1, 1'b0, 1'b1, 19'd6, 4'hE, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 19'd7, 4'h1, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 8'h55, 1'b1, 1'b0, 19'd7, 4'h1, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 8'h55, 1'b1, 1'b0, 19'd7, 4'h1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 19'd7, 4'h1, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 8'hA5, 1'b1, 1'b0, 19'd7, 4'h1, 1'b1, 1'b0};

        // Reset state
        #7;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.wr_en", wr_en, 0);
        chk("rst.wr_addr", wr_addr, 0);
        chk("rst.wr_data", wr_data, 0);
        chk("rst.busy", busy, 0);
        chk("rst.frame_done", frame_done, 0);
        chk("rst.abort", abort, 0);
        @(negedge clk);
        rst = 1'b0;

        // Cycle-exact table: idle drops, sync, pair writes, in-frame A5, frame end
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.in_ready", i), in_ready, tbl[i].rdy);
            chk($sformatf("vec%0d.wr_en", i), wr_en, tbl[i].we);
            chk($sformatf("vec%0d.wr_addr", i), wr_addr, tbl[i].a);
            chk($sformatf("vec%0d.wr_data", i), wr_data, tbl[i].wd);
            chk($sformatf("vec%0d.busy", i), busy, tbl[i].bsy);
            chk($sformatf("vec%0d.frame_done", i), frame_done, tbl[i].dn);
            chk($sformatf("vec%0d.abort", i), abort, 0);
        end

        // Asynchronous reset between the two nibble writes
        do_reset();
        send(8'hA5, ok);
        send(8'h96, ok);
        #1;
        chk("arst.pre_wr_en", wr_en, 1);
        chk("arst.pre_wr_data", wr_data, 4'h9);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("arst.wr_en", wr_en, 0);
        chk("arst.busy", busy, 0);
        chk("arst.wr_addr", wr_addr, 0);
        chk("arst.in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (wr_en) n_done++;
        end
        chk("arst.no_late_write", n_done, 0);
        chk("arst.busy_after", busy, 0);
        chk("arst.wr_addr_after", wr_addr, 0);

        // Stall in RECV: abort only with the timeout feature
        do_reset();
        send(8'hA5, ok);
        send(8'h3C, ok);
        @(negedge clk);
        in_valid = 1'b0;
        n_abort = 0;
        n_done  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (abort) n_abort++;
            if (frame_done) n_done++;
        end
        chk("stall.frame_done", n_done, 0);
`ifdef FB_WRITER_TIMEOUT_EN
        chk("stall.abort_pulses", n_abort, 1);
        chk("stall.busy", busy, 0);
        send(8'hA5, ok);
        send(8'h12, ok);
        #1;
        chk("restart.wr_en", wr_en, 1);
        chk("restart.wr_addr", wr_addr, 0);
        chk("restart.wr_data", wr_data, 4'h1);
`else
        chk("stall.abort_pulses", n_abort, 0);
        chk("stall.busy", busy, 1);
        send(8'hA5, ok);
        #1;
        chk("resume.wr_en", wr_en, 1);
        chk("resume.wr_addr", wr_addr, 2);
        chk("resume.wr_data", wr_data, 4'hA);
`endif

        // Randomized stream against a transaction-level frame model
        do_reset();
        got.delete();
        got_done = 0;
        exp_done = 0;
        in_frame = 1'b0;
        pix = 0;
        mon_en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            b = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
            send(b, ok);
            if (ok) begin
                if (!in_frame) begin
                    if (b == 8'hA5) begin
                        in_frame = 1'b1;
                        pix = 0;
                    end
                end else begin
                    expq.push_back({19'(pix), b[7:4]});
                    expq.push_back({19'(pix + 1), b[3:0]});
                    pix += 2;
                    if (pix == SZ) begin
                        exp_done++;
                        in_frame = 1'b0;
                    end
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        chk("rand.write_count", got.size(), expq.size());
        chk("rand.frame_done_count", got_done, exp_done);
        for (int k = 0; k < expq.size() && k < got.size(); k++)
            chk($sformatf("rand.write%0d", k), got[k], expq[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
